pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and instruction-fetch sequencer for the LEGv8 core.
//  Sits directly downstream of the next-PC select mux and consumes its data_out as next_pc_in.
//  Drives instruction memory through a req/ack handshake and presents the fetched word to decode.
//  Produces pc_plus4, which feeds back to the mux's sequential input (adder_1).
// PARAMETERS
//  ADDR_WIDTH  32  width of PC, next_pc_in and imem_addr
//  RESET_PC    0   PC value loaded on reset
//  PC_STEP     4   increment used for pc_plus4
//  MAX_WAIT    15  cycles REQ may wait for imem_ack before a timeout error
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           synchronous, active-high reset
//  next_pc_in   in   ADDR_WIDTH  next PC from the select mux (data_out)
//  stall        in   1           hazard stall from decode; holds PC and instruction
//  imem_ack     in   1           instruction memory has valid data this cycle
//  imem_rdata   in   32          instruction word; valid when imem_ack=1
//  imem_req     out  1           fetch request
//  imem_addr    out  ADDR_WIDTH  fetch address (always equals pc_out)
//  pc_out       out  ADDR_WIDTH  current PC
//  pc_plus4     out  ADDR_WIDTH  pc_out+PC_STEP (combinational)
//  instr_out    out  32          last fetched instruction
//  instr_valid  out  1           instr_out is valid for decode
//  fetch_error  out  1           sticky error: timeout or misaligned PC
// BEHAVIOUR
//  - Clock/reset: one clock; reset is synchronous and active-high.
//  - Registered outputs: all outputs are registered except pc_plus4.
//  - Reset values: pc_out=RESET_PC, imem_req=0, instr_out=0, instr_valid=0,
//    fetch_error=0, wait_cnt=0, state=IDLE.
//  - Reset mid-operation: the next edge returns to reset values and abandons any
//    outstanding request. Any late imem_ack is ignored.
//  - IDLE: always moves to REQ on the next edge, so first imem_req is 1 cycle after
//    reset deasserts.
//  - REQ:
//    - imem_req=1 and imem_addr=pc_out; both are held stable until imem_ack.
//    - wait_cnt increments each cycle without ack; wait_cnt==MAX_WAIT with no ack
//      -> ERROR.
//    - On imem_ack: instr_out<=imem_rdata, instr_valid<=1, imem_req<=0,
//      wait_cnt<=0, -> VALID.
//  - VALID: instr_valid=1.
//    - stall=1: hold PC, instr_out and state.
//    - stall=0 and next_pc_in[1:0]==0: pc_out<=next_pc_in, instr_valid<=0, -> REQ.
//    - stall=0 and next_pc_in[1:0]!=0: pc_out is unchanged, instr_valid<=0, -> ERROR.
//  - ERROR: fetch_error=1 and imem_req=0. Only reset exits this state.
//  - imem_ack outside REQ is ignored.
//  - Latency: ack sampled at edge N -> instr_valid high after edge N.
//    Minimum fetch period is 2 cycles (REQ with same-cycle ack, then VALID).
//  - Arithmetic: pc_plus4 wraps modulo 2^ADDR_WIDTH (all-ones minus 3 -> 0).
//    No carry out.
//  - Simultaneous stall and ack while in REQ: the ack is captured. Stall only
//    affects VALID.
// TESTING
//  1 Reset: assert reset 2 cycles -> pc_out=0, imem_req=0, instr_valid=0;
//    imem_req=1 with imem_addr=0 one cycle after release.
//  2 Sequential fetch: ack same cycle as req, rdata=0x8B020020, next_pc_in=pc_plus4
//    -> instr_valid pulses every 2nd cycle; addresses 0,4,8,C.
//  3 Branch plus stall: in VALID hold stall=1 for 3 cycles, then next_pc_in=0x40
//    -> pc_out holds for 3 cycles, then becomes 0x40 and next imem_addr=0x40.
//  4 Slow memory/timeout: delay ack 5 cycles -> req and addr stable, captured
//    correctly; withhold ack 16 cycles -> fetch_error=1, imem_req=0.
//  5 Misaligned and wrap: next_pc_in=0x42 -> ERROR with pc_out unchanged;
//    after reset with RESET_PC=0xFFFFFFFC -> pc_plus4=0.
//  6 Reset mid-wait: reset during REQ, then late ack -> ack ignored,
//    instr_valid=0, restart at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer for the LEGv8 core.
// Drives imem through req/ack and presents fetched words to decode.
module pc_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] next_pc_in,
  input  logic                  stall,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [31:0]           instr_out,
  output logic                  instr_valid,
  output logic                  fetch_error
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    VALID,
    ERROR
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  // Fetch address is the PC itself; increment wraps with no carry out
  assign imem_addr = pc_out;
  assign pc_plus4  = pc_out + ADDR_WIDTH'(PC_STEP);

  // Fetch sequencer: all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc_out      <= RESET_PC;
      imem_req    <= 1'b0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      fetch_error <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          wait_cnt <= '0;
        end
        REQ: begin
          if (imem_ack) begin
            instr_out   <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            wait_cnt    <= '0;
            state       <= VALID;
          end else if (wait_cnt == CW'(MAX_WAIT)) begin
            imem_req    <= 1'b0;
            fetch_error <= 1'b1;
            state       <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        VALID: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (next_pc_in[1:0] == 2'b00) begin
              pc_out   <= next_pc_in;
              imem_req <= 1'b1;
              state    <= REQ;
            end else begin
              fetch_error <= 1'b1;
              state       <= ERROR;
            end
          end
        end
        ERROR: begin
          imem_req    <= 1'b0;
          fetch_error <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: vector table plus
// hand-written timeout-boundary and PC-wrap sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc_in;
  logic        stall;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req, instr_valid, fetch_error;
  logic [31:0] imem_addr, pc_out, pc_plus4, instr_out;

  logic        w_req, w_valid, w_err;
  logic [31:0] w_addr, w_pc, w_plus4, w_instr;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .next_pc_in(next_pc_in),
    .stall(stall), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .instr_out(instr_out),
    .instr_valid(instr_valid), .fetch_error(fetch_error)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .next_pc_in(next_pc_in),
    .stall(stall), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(w_req), .imem_addr(w_addr), .pc_out(w_pc),
    .pc_plus4(w_plus4), .instr_out(w_instr),
    .instr_valid(w_valid), .fetch_error(w_err)
  );

  typedef struct {
    logic        rst, stl, ack;
    logic [31:0] rdata, npc;
    bit          chk;
    logic [31:0] pc;
    logic        req, v, err;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, stl, ack,
                     input logic [31:0] rdata, npc,
                     input bit chk, input logic [31:0] pc,
                     input logic req, v, err,
                     input logic [31:0] instr);
    vec_t r;
    r.rst = rst; r.stl = stl; r.ack = ack;
    r.rdata = rdata; r.npc = npc; r.chk = chk;
    r.pc = pc; r.req = req; r.v = v; r.err = err;
    r.instr = instr;
    tbl.push_back(r);
  endtask

  task automatic cmp(input string nm, input int row,
                     input logic [31:0] got, exp);
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s row %0d: got %h expected %h",
               nm, row, got, exp);
    end
  endtask

  task automatic one(input string nm, input logic [31:0] got, exp);
    nvec++;
    cmp(nm, -1, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] W0 = 32'h8B02_0020;
  localparam logic [31:0] W1 = 32'h8B02_0024;
  localparam logic [31:0] W2 = 32'h8B02_0028;
  localparam logic [31:0] W3 = 32'h8B02_002C;
  localparam logic [31:0] BF = 32'hDEAD_BEEF;
  localparam logic [31:0] A1 = 32'hAAAA_0001;
  localparam logic [31:0] C5 = 32'h5555_5555;

  initial begin
    // rst stl ack rdata npc | chk pc req v err instr
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, W0, 4, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 4, 1, 0, 0, 1, 0, W0);
    add(0, 0, 1, W1, 8, 1, 4, 1, 0, 0, W0);
    add(0, 0, 0, 0, 8, 1, 4, 0, 1, 0, W1);
    add(0, 0, 1, W2, 'hC, 1, 8, 1, 0, 0, W1);
    add(0, 0, 0, 0, 'hC, 1, 8, 0, 1, 0, W2);
    add(0, 0, 1, W3, 'h40, 1, 'hC, 1, 0, 0, W2);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 0, 'h40, 1, 'hC, 0, 1, 0, W3);
    add(0, 0, 0, 0, 'h40, 1, 'hC, 0, 1, 0, W3);
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 0, 0, 1, 'h40, 1, 0, 0, W3);
    add(0, 1, 1, BF, 0, 1, 'h40, 1, 0, 0, W3);
    add(0, 0, 0, 0, 'h44, 1, 'h40, 0, 1, 0, BF);
    for (int i = 0; i < 16; i++)
      add(0, 0, 0, 0, 0, 1, 'h44, 1, 0, 0, BF);
    add(0, 0, 1, 'h1234_5678, 0, 1, 'h44, 0, 0, 1, BF);
    add(1, 0, 1, 'h1234_5678, 0, 1, 'h44, 0, 0, 1, BF);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, A1, 4, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 'h42, 1, 0, 0, 1, 0, A1);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, A1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(1, 0, 1, C5, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, C5, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      reset      = tbl[i].rst;
      stall      = tbl[i].stl;
      imem_ack   = tbl[i].ack;
      imem_rdata = tbl[i].rdata;
      next_pc_in = tbl[i].npc;
      if (tbl[i].chk) begin
        nvec++;
        cmp("pc_out", i, pc_out, tbl[i].pc);
        cmp("imem_addr", i, imem_addr, tbl[i].pc);
        cmp("pc_plus4", i, pc_plus4, tbl[i].pc + 32'd4);
        cmp("imem_req", i, 32'(imem_req), 32'(tbl[i].req));
        cmp("instr_valid", i, 32'(instr_valid), 32'(tbl[i].v));
        cmp("fetch_error", i, 32'(fetch_error), 32'(tbl[i].err));
        cmp("instr_out", i, instr_out, tbl[i].instr);
      end
      step();
    end

    // ack on the last allowed wait cycle is still captured
    reset = 1; imem_ack = 0; stall = 0; next_pc_in = 0;
    step();
    reset = 0;
    step();
    for (int i = 0; i < 15; i++) begin
      one("req_wait", 32'(imem_req), 32'd1);
      step();
    end
    imem_ack = 1; imem_rdata = 32'h0000_0777;
    one("req_last", 32'(imem_req), 32'd1);
    step();
    imem_ack = 0;
    one("late_valid", 32'(instr_valid), 32'd1);
    one("late_instr", instr_out, 32'h0000_0777);
    one("late_err", 32'(fetch_error), 32'd0);

    // PC near the top of the space wraps to zero
    reset = 1;
    step();
    one("wrap_pc", w_pc, 32'hFFFF_FFFC);
    one("wrap_plus4", w_plus4, 32'd0);
    reset = 0;
    step();
    step();
    one("wrap_req", 32'(w_req), 32'd1);
    one("wrap_addr", w_addr, 32'hFFFF_FFFC);
    imem_ack = 1; imem_rdata = 32'h0000_0099;
    step();
    imem_ack = 0; stall = 0; next_pc_in = 32'd0;
    one("wrap_valid", 32'(w_valid), 32'd1);
    one("wrap_instr", w_instr, 32'h0000_0099);
    step();
    one("wrap_newpc", w_pc, 32'd0);
    one("wrap_newreq", 32'(w_req), 32'd1);
    one("wrap_newp4", w_plus4, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
